// File: rtl/lynxTypes.sv
// Shared types for the DMA request/done protocol and the ISR responder tracking queue.
package lynxTypes;

  localparam int PADDR_BITS    = 48;
  localparam int LEN_BITS      = 28;
  localparam int N_OUTSTANDING = 8;

  // Tracking entries are sized for the default 4 KiB chunk boundary.
  localparam int DMA_ISR_CHUNK_BITS = 12;
  localparam int DMA_ISR_NCHK_BITS  = LEN_BITS - DMA_ISR_CHUNK_BITS + 1;

  typedef struct packed {
    logic [PADDR_BITS-1:0] paddr;
    logic [LEN_BITS-1:0]   len;
    logic                  ctl;
    logic [7:0]            rsrvd;
  } dma_req_t;

  typedef struct packed {
    logic       done;
    logic [7:0] rsrvd;
  } dma_rsp_t;

  typedef struct packed {
    logic                         ctl;
    logic [DMA_ISR_NCHK_BITS-1:0] nchk;
  } dma_isr_trk_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } dma_isr_state_t;

endpackage

// File: rtl/dmaIntf.sv
// Valid/ready DMA request channel with a done pulse returned on rsp.
interface dmaIntf;
  import lynxTypes::*;

  logic     valid;
  logic     ready;
  dma_req_t req;
  dma_rsp_t rsp;

  modport m (output valid, output req, input ready, input rsp);
  modport s (input valid, input req, output ready, output rsp);
endinterface

// File: rtl/queue.sv
// Circular FIFO; a pop in the same cycle frees a slot for a push even when full.
module queue #(
  parameter type QTYPE  = logic [31:0],
  parameter int  QDEPTH = 8
) (
  input  logic aclk,
  input  logic areset,
  input  logic val_snk,
  output logic rdy_snk,
  input  QTYPE data_snk,
  output logic val_src,
  input  logic rdy_src,
  output QTYPE data_src
);

  localparam int            AW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(QDEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(QDEPTH - 1);

  QTYPE          mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_s, pop_s;

  assign val_src  = (cnt_q != '0);
  assign rdy_snk  = (cnt_q != FULL_CNT) || rdy_src;
  assign push_s   = val_snk && rdy_snk;
  assign pop_s    = val_src && rdy_src;
  assign data_src = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_snk;
    end
  end

endmodule

// File: rtl/tlb_isr_dma_responder.sv
// DMA responder: splits each request into page-bounded engine commands and
// pulses rsp.done, in request order, once all chunks of a ctl request complete.
module tlb_isr_dma_responder
  import lynxTypes::*;
#(
  parameter bit RDWR           = 1'b0,
  parameter int MAX_CHUNK_BITS = 12,
  parameter int QDEPTH         = N_OUTSTANDING
) (
  input  logic                    aclk,
  input  logic                    areset,
  dmaIntf.s                       s_req,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  output logic [PADDR_BITS-1:0]   m_cmd_addr,
  output logic [MAX_CHUNK_BITS:0] m_cmd_len,
  output logic                    m_cmd_last,
  output logic                    m_cmd_wr,
  input  logic                    m_cpl_valid,
  output logic                    busy,
  output logic [31:0]             stat_req_cnt
);

  localparam int NW = DMA_ISR_NCHK_BITS;
  localparam logic [MAX_CHUNK_BITS:0] CHUNK_BYTES = {1'b1, {MAX_CHUNK_BITS{1'b0}}};

  function automatic logic [MAX_CHUNK_BITS:0] chunk_len(input logic [PADDR_BITS-1:0] a,
                                                        input logic [LEN_BITS-1:0] r);
    logic [MAX_CHUNK_BITS:0] room;
    room = CHUNK_BYTES - {1'b0, a[MAX_CHUNK_BITS-1:0]};
    if (r < LEN_BITS'(room)) chunk_len = r[MAX_CHUNK_BITS:0];
    else                     chunk_len = room;
  endfunction

  dma_isr_state_t          state_q, state_d;
  logic [PADDR_BITS-1:0]   addr_q, addr_d, cmd_addr_q, cmd_addr_d;
  logic [LEN_BITS-1:0]     rem_q, rem_d;
  logic [NW-1:0]           nchk_q, nchk_d, cacc_q, cacc_d;
  logic                    ctl_q, ctl_d, done_q, done_d;
  logic                    cmd_valid_q, cmd_valid_d, cmd_last_q, cmd_last_d;
  logic [MAX_CHUNK_BITS:0] cmd_len_q, cmd_len_d, clen_in_s, clen_nx_s;
  logic [31:0]             req_cnt_q, req_cnt_d;
  logic                    accept_s, cmd_hs_s, q_push_s, q_rdy_s, q_val_s, retire_s;
  dma_isr_trk_t            q_in_s, head_s;
  logic                    unused_s;

  assign unused_s  = ^s_req.req.rsrvd;
  assign clen_in_s = chunk_len(s_req.req.paddr, s_req.req.len);
  assign clen_nx_s = chunk_len(addr_q, rem_q);

  assign s_req.ready = (state_q == ST_IDLE) && q_rdy_s && !areset;
  assign accept_s    = s_req.valid && s_req.ready;
  assign cmd_hs_s    = cmd_valid_q && m_cmd_ready;
  assign retire_s    = q_val_s && (cacc_q >= head_s.nchk);

  // Zero-length requests push from IDLE; split requests push on their last handshake.
  assign q_push_s    = (accept_s && (s_req.req.len == '0)) ||
                       ((state_q == ST_SPLIT) && cmd_hs_s && cmd_last_q);
  assign q_in_s.ctl  = (state_q == ST_IDLE) ? s_req.req.ctl : ctl_q;
  assign q_in_s.nchk = (state_q == ST_IDLE) ? '0 : nchk_q + 1'b1;

  queue #(.QTYPE(dma_isr_trk_t), .QDEPTH(QDEPTH)) inst_trk_q (
    .aclk     (aclk),
    .areset   (areset),
    .val_snk  (q_push_s),
    .rdy_snk  (q_rdy_s),
    .data_snk (q_in_s),
    .val_src  (q_val_s),
    .rdy_src  (retire_s),
    .data_src (head_s)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      nchk_q      <= '0;
      ctl_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_last_q  <= 1'b0;
      cacc_q      <= '0;
      done_q      <= 1'b0;
      req_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      nchk_q      <= nchk_d;
      ctl_q       <= ctl_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      cmd_last_q  <= cmd_last_d;
      cacc_q      <= cacc_d;
      done_q      <= done_d;
      req_cnt_q   <= req_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_s && (s_req.req.len != '0)) state_d = ST_SPLIT;
      ST_SPLIT: if (cmd_hs_s && cmd_last_q)             state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // addr/rem track the bytes after the chunk currently presented on m_cmd.
  always_comb begin
    addr_d      = addr_q;
    rem_d       = rem_q;
    nchk_d      = nchk_q;
    ctl_d       = ctl_q;
    req_cnt_d   = req_cnt_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    cmd_last_d  = cmd_last_q;
    if (accept_s) begin
      nchk_d    = '0;
      ctl_d     = s_req.req.ctl;
      req_cnt_d = req_cnt_q + 32'd1;
      if (s_req.req.len != '0) begin
        cmd_valid_d = 1'b1;
        cmd_addr_d  = s_req.req.paddr;
        cmd_len_d   = clen_in_s;
        cmd_last_d  = (s_req.req.len == LEN_BITS'(clen_in_s));
        addr_d      = s_req.req.paddr + PADDR_BITS'(clen_in_s);
        rem_d       = s_req.req.len - LEN_BITS'(clen_in_s);
      end else begin
        addr_d = s_req.req.paddr;
        rem_d  = '0;
      end
    end else if (cmd_hs_s) begin
      nchk_d = nchk_q + 1'b1;
      if (cmd_last_q) begin
        cmd_valid_d = 1'b0;
      end else begin
        cmd_addr_d = addr_q;
        cmd_len_d  = clen_nx_s;
        cmd_last_d = (rem_q == LEN_BITS'(clen_nx_s));
        addr_d     = addr_q + PADDR_BITS'(clen_nx_s);
        rem_d      = rem_q - LEN_BITS'(clen_nx_s);
      end
    end else begin
      cmd_valid_d = cmd_valid_q;
    end
    // Completions may run ahead of the entry they belong to.
    cacc_d = cacc_q + NW'(m_cpl_valid) - (retire_s ? head_s.nchk : '0);
    done_d = retire_s && head_s.ctl;
  end

  always_comb begin
    s_req.rsp      = '0;
    s_req.rsp.done = done_q;
  end

  assign m_cmd_valid  = cmd_valid_q;
  assign m_cmd_addr   = cmd_addr_q;
  assign m_cmd_len    = cmd_len_q;
  assign m_cmd_last   = cmd_last_q;
  assign m_cmd_wr     = RDWR;
  assign busy         = (state_q != ST_IDLE) || q_val_s;
  assign stat_req_cnt = req_cnt_q;

endmodule

// File: tb/tb_tlb_isr_dma_responder.sv
// Directed bench for tlb_isr_dma_responder with a 2-entry tracking queue.
module tb_tlb_isr_dma_responder;
  import lynxTypes::*;

  logic                  aclk = 1'b0;
  logic                  areset;
  logic                  m_cmd_valid, m_cmd_ready, m_cmd_last, m_cmd_wr, m_cpl_valid, busy;
  logic [PADDR_BITS-1:0] m_cmd_addr;
  logic [12:0]           m_cmd_len;
  logic [31:0]           stat_req_cnt;
  int checks = 0, errors = 0, hs_cnt = 0, done_cnt = 0;

  dmaIntf req_if ();

  always #5 aclk = ~aclk;

  tlb_isr_dma_responder #(.RDWR(1'b0), .MAX_CHUNK_BITS(12), .QDEPTH(2)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_req        (req_if),
    .m_cmd_valid  (m_cmd_valid),
    .m_cmd_ready  (m_cmd_ready),
    .m_cmd_addr   (m_cmd_addr),
    .m_cmd_len    (m_cmd_len),
    .m_cmd_last   (m_cmd_last),
    .m_cmd_wr     (m_cmd_wr),
    .m_cpl_valid  (m_cpl_valid),
    .busy         (busy),
    .stat_req_cnt (stat_req_cnt)
  );

  // Samples handshakes and done pulses once per cycle, then advances to 1 ns past the edge.
  task automatic tick();
    if (m_cmd_valid && m_cmd_ready) hs_cnt++;
    if (req_if.rsp.done) done_cnt++;
    @(posedge aclk);
    #1;
  endtask

  task automatic cpl_pulse();
    m_cpl_valid = 1'b1;
    tick();
    m_cpl_valid = 1'b0;
  endtask

  task automatic send(input logic [PADDR_BITS-1:0] pa, input logic [LEN_BITS-1:0] ln,
                      input logic c, input string nm);
    int n = 0;
    req_if.valid = 1'b1; req_if.req.paddr = pa; req_if.req.len = ln;
    req_if.req.ctl = c;  req_if.req.rsrvd = 8'hA5;
    while (!req_if.ready && n < 50) begin tick(); n++; end
    checks++; if (req_if.ready !== 1'b1) begin errors++; $display("FAIL %s_accept ready=%b after %0d cycles, required 1", nm, req_if.ready, n); end
    tick();
    req_if.valid = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; m_cmd_ready = 1'b0; m_cpl_valid = 1'b0; req_if.valid = 1'b0;
    req_if.req = '0;
    tick(); tick();
    checks++; if (req_if.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b required 0", req_if.ready); end
    checks++; if (req_if.rsp !== '0) begin errors++; $display("FAIL rst_rsp got %h required 0", req_if.rsp); end
    checks++; if ({m_cmd_valid, m_cmd_last, m_cmd_wr, busy} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b required 0000", {m_cmd_valid, m_cmd_last, m_cmd_wr, busy}); end
    checks++; if (m_cmd_addr !== 48'h0 || m_cmd_len !== 13'h0) begin errors++; $display("FAIL rst_payload got %h/%h required 0/0", m_cmd_addr, m_cmd_len); end
    checks++; if (stat_req_cnt !== 32'd0) begin errors++; $display("FAIL rst_stat got %0d required 0", stat_req_cnt); end
    areset = 1'b0;
    #1;
    checks++; if (req_if.ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b required 1", req_if.ready); end
  endtask

  task automatic test_split_4k();
    done_cnt = 0; m_cmd_ready = 1'b1;
    send(48'h1000, 28'h2000, 1'b1, "s4k");
    checks++; if ({m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_last} !== {1'b1, 48'h1000, 13'd4096, 1'b0}) begin errors++; $display("FAIL s4k_chunk0 got v=%b a=%h l=%0d last=%b required 1/1000/4096/0", m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_last); end
    tick();
    checks++; if ({m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_last} !== {1'b1, 48'h2000, 13'd4096, 1'b1}) begin errors++; $display("FAIL s4k_chunk1 got v=%b a=%h l=%0d last=%b required 1/2000/4096/1", m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_last); end
    tick();
    checks++; if ({m_cmd_valid, busy, req_if.ready} !== 3'b011) begin errors++; $display("FAIL s4k_after_last got valid/busy/ready=%b required 011", {m_cmd_valid, busy, req_if.ready}); end
    cpl_pulse(); tick(); tick();
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL s4k_early_done got %0d pulses required 0", done_cnt); end
    cpl_pulse();
    checks++; if (req_if.rsp.done !== 1'b0) begin errors++; $display("FAIL s4k_done_c1 got %b required 0", req_if.rsp.done); end
    tick();
    checks++; if (req_if.rsp.done !== 1'b1) begin errors++; $display("FAIL s4k_done_c2 got %b required 1", req_if.rsp.done); end
    tick();
    checks++; if (req_if.rsp.done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL s4k_done_c3 got done/busy=%b%b required 00", req_if.rsp.done, busy); end
    checks++; if (stat_req_cnt !== 32'd1) begin errors++; $display("FAIL s4k_stat got %0d required 1", stat_req_cnt); end
  endtask

  task automatic test_unaligned();
    done_cnt = 0;
    send(48'h0FF0, 28'h30, 1'b0, "unal");
    checks++; if ({m_cmd_addr, m_cmd_len, m_cmd_last} !== {48'h0FF0, 13'h10, 1'b0}) begin errors++; $display("FAIL unal_chunk0 got a=%h l=%h last=%b required 0ff0/10/0", m_cmd_addr, m_cmd_len, m_cmd_last); end
    tick();
    checks++; if ({m_cmd_addr, m_cmd_len, m_cmd_last} !== {48'h1000, 13'h20, 1'b1}) begin errors++; $display("FAIL unal_chunk1 got a=%h l=%h last=%b required 1000/20/1", m_cmd_addr, m_cmd_len, m_cmd_last); end
    tick();
    cpl_pulse(); cpl_pulse(); tick(); tick(); tick();
    checks++; if (done_cnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL unal_silent got done pulses=%0d busy=%b required 0/0", done_cnt, busy); end
  endtask

  task automatic test_two_req();
    done_cnt = 0;
    send(48'h4000, 28'h1800, 1'b0, "twoA");
    tick(); tick();
    send(48'h8000, 28'h100, 1'b1, "twoB");
    checks++; if ({m_cmd_addr, m_cmd_len, m_cmd_last} !== {48'h8000, 13'h100, 1'b1}) begin errors++; $display("FAIL two_chunkB got a=%h l=%h last=%b required 8000/100/1", m_cmd_addr, m_cmd_len, m_cmd_last); end
    tick();
    cpl_pulse(); tick(); tick(); tick();
    cpl_pulse(); tick(); tick(); tick();
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL two_no_done_yet got %0d pulses required 0", done_cnt); end
    cpl_pulse(); tick();
    checks++; if (req_if.rsp.done !== 1'b1) begin errors++; $display("FAIL two_done_c2 got %b required 1", req_if.rsp.done); end
    tick(); tick();
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL two_done_count got %0d required 1", done_cnt); end
  endtask

  task automatic test_back_pressure();
    int bad = 0;
    done_cnt = 0; hs_cnt = 0; m_cmd_ready = 1'b0;
    send(48'h10000, 28'h3000, 1'b1, "bp");
    m_cmd_ready = 1'b1;
    tick();
    m_cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_last} !== {1'b1, 48'h11000, 13'd4096, 1'b0}) bad++;
      tick();
    end
    checks++; if (bad !== 0 || m_cmd_addr !== 48'h11000) begin errors++; $display("FAIL bp_stable got %0d unstable cycles addr=%h required 0/11000", bad, m_cmd_addr); end
    m_cmd_ready = 1'b1;
    tick();
    checks++; if ({m_cmd_addr, m_cmd_last} !== {48'h12000, 1'b1}) begin errors++; $display("FAIL bp_chunk2 got a=%h last=%b required 12000/1", m_cmd_addr, m_cmd_last); end
    tick();
    checks++; if (m_cmd_valid !== 1'b0 || hs_cnt !== 3) begin errors++; $display("FAIL bp_handshakes got valid=%b hs=%0d required 0/3", m_cmd_valid, hs_cnt); end
    cpl_pulse(); cpl_pulse(); tick(); tick(); tick();
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL bp_nchk_early got %0d pulses required 0", done_cnt); end
    cpl_pulse(); tick();
    checks++; if (req_if.rsp.done !== 1'b1) begin errors++; $display("FAIL bp_done got %b required 1", req_if.rsp.done); end
    tick();
  endtask

  task automatic test_queue_full();
    int rdy_seen = 0;
    done_cnt = 0;
    send(48'h20000, 28'h40, 1'b1, "qf1"); tick();
    send(48'h21000, 28'h40, 1'b1, "qf2"); tick();
    req_if.valid = 1'b1; req_if.req.paddr = 48'h22000; req_if.req.len = 28'h40; req_if.req.ctl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (req_if.ready) rdy_seen++;
      tick();
    end
    checks++; if (rdy_seen !== 0 || busy !== 1'b1) begin errors++; $display("FAIL qf_blocked got ready cycles=%0d busy=%b required 0/1", rdy_seen, busy); end
    m_cpl_valid = 1'b1;
    checks++; if (req_if.ready !== 1'b0) begin errors++; $display("FAIL qf_ready_c got %b required 0", req_if.ready); end
    tick();
    m_cpl_valid = 1'b0;
    checks++; if (req_if.ready !== 1'b1) begin errors++; $display("FAIL qf_ready_c1 got %b required 1", req_if.ready); end
    tick();
    req_if.valid = 1'b0;
    checks++; if ({req_if.rsp.done, m_cmd_valid, m_cmd_addr} !== {1'b1, 1'b1, 48'h22000}) begin errors++; $display("FAIL qf_c2 got done=%b v=%b a=%h required 1/1/22000", req_if.rsp.done, m_cmd_valid, m_cmd_addr); end
    tick();
    cpl_pulse(); tick(); tick(); tick();
    cpl_pulse(); tick(); tick(); tick();
    checks++; if (done_cnt !== 3 || busy !== 1'b0) begin errors++; $display("FAIL qf_drain got pulses=%0d busy=%b required 3/0", done_cnt, busy); end
  endtask

  task automatic test_zero_len();
    done_cnt = 0;
    send(48'h30000, 28'h80, 1'b1, "zl1"); tick();
    send(48'h31000, 28'h0, 1'b1, "zl0");
    checks++; if (m_cmd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zl_no_cmd got valid=%b busy=%b required 0/1", m_cmd_valid, busy); end
    tick(); tick(); tick();
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL zl_blocked got %0d pulses required 0", done_cnt); end
    cpl_pulse(); tick();
    checks++; if (req_if.rsp.done !== 1'b1) begin errors++; $display("FAIL zl_done_first got %b required 1", req_if.rsp.done); end
    tick();
    checks++; if (req_if.rsp.done !== 1'b1) begin errors++; $display("FAIL zl_done_second got %b required 1", req_if.rsp.done); end
    tick();
    checks++; if (req_if.rsp.done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zl_end got done/busy=%b%b required 00", req_if.rsp.done, busy); end
  endtask

  task automatic test_reset_mid();
    m_cmd_ready = 1'b0;
    send(48'h40000, 28'h2000, 1'b1, "rm");
    checks++; if ({m_cmd_valid, busy} !== 2'b11 || stat_req_cnt !== 32'd11) begin errors++; $display("FAIL rm_pre got v/busy=%b%b stat=%0d required 11/11", m_cmd_valid, busy, stat_req_cnt); end
    areset = 1'b1;
    #1;
    checks++; if (req_if.ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_reset got %b required 0", req_if.ready); end
    tick();
    checks++; if ({m_cmd_valid, m_cmd_last, busy, req_if.rsp.done} !== 4'b0000 || m_cmd_addr !== 48'h0 || m_cmd_len !== 13'h0 || stat_req_cnt !== 32'd0) begin errors++; $display("FAIL rm_cleared got v=%b last=%b busy=%b done=%b a=%h l=%h stat=%0d required all 0", m_cmd_valid, m_cmd_last, busy, req_if.rsp.done, m_cmd_addr, m_cmd_len, stat_req_cnt); end
    areset = 1'b0;
    tick();
    checks++; if (req_if.ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rm_release got ready/busy=%b%b required 10", req_if.ready, busy); end
  endtask

  initial begin
    test_reset();
    test_split_4k();
    test_unaligned();
    test_two_req();
    test_back_pressure();
    test_queue_full();
    test_zero_len();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
